// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM states, word geometry and the PC increment helper.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TRAP = 2'd3
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle between fetch, instruction memory, branch resolution and decode.
// misalign_o exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic [31:0]        imem_addr_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic               redirect_i;
  logic [31:0]        redirect_pc_i;
  logic               id_ready_i;
  logic               id_valid_o;
  logic [INSTR_W-1:0] id_instr_o;
  logic [31:0]        id_pc_o;
  logic [31:0]        id_pc_plus4_o;
  logic               halted_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic               misalign_o;
`endif

  // Fetch stage side.
  modport master (
    output imem_addr_o,
    input  imem_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  id_ready_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc_o,
    output id_pc_plus4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output misalign_o,
`endif
    output halted_o
  );

  // Memory / redirect source / decode side.
  modport slave (
    input  imem_addr_o,
    output imem_data_i,
    output redirect_i,
    output redirect_pc_i,
    output id_ready_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc_o,
    input  id_pc_plus4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  misalign_o,
`endif
    input  halted_o
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / +4 / redirect selection and
// the end-of-image comparisons used by the fetch FSM.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc_q,
  output logic        at_end,
  output logic        target_past_end
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - PC_STEP);

  logic [31:0] pc_next;

  // Redirect wins over a sequential advance.
  always_comb begin
    pc_next = pc_q;
    if (redirect)
      pc_next = target;
    else if (advance)
      pc_next = pc_inc(pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_next;
  end

  assign at_end          = (pc_q == LAST_ADDR);
  assign target_past_end = (target > LAST_ADDR);

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC ownership, IF/ID register with valid/ready toward decode,
// redirect flush and end-of-image halt. FETCH_MISALIGN_TRAP_EN adds a TRAP state.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  fetch_state_e       state, state_next;
  logic               load;
  logic [31:0]        pc_q;
  logic               at_end;
  logic               target_past_end;
  logic [31:0]        target;

  logic               vld_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [31:0]        pc_p1;
  logic [31:0]        pc_plus4_p1;
  logic               halted_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic               misaligned;
  logic               misalign_q;

  assign target     = bus.redirect_pc_i;
  assign misaligned = |bus.redirect_pc_i[1:0];
`else
  // Low address bits are ignored so every fetch stays word aligned.
  assign target     = bus.redirect_pc_i & ~32'h3;
`endif

  fetch_pc_gen #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .advance         (load),
    .redirect        (bus.redirect_i),
    .target          (target),
    .pc_q            (pc_q),
    .at_end          (at_end),
    .target_past_end (target_past_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = (state == RUN) && (!vld_p1 || bus.id_ready_i) && !bus.redirect_i;

    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (load && at_end) state_next = HALT;
      default: state_next = state;
    endcase

    // A redirect overrides whatever the current state would do.
    if (bus.redirect_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned)
        state_next = TRAP;
      else
`endif
      if (target_past_end)
        state_next = HALT;
      else
        state_next = RUN;
    end
  end

  // ---- p1: IF/ID register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
    end else if (bus.redirect_i) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1      <= 1'b1;
      instr_p1    <= bus.imem_data_i;
      pc_p1       <= pc_q;
      pc_plus4_p1 <= pc_inc(pc_q);
    end else if (bus.id_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      halted_q <= 1'b0;
    else
      halted_q <= (state_next == HALT);
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else
      misalign_q <= (state_next == TRAP);
  end

  assign bus.misalign_o = misalign_q;
`endif

  assign bus.imem_addr_o   = pc_q;
  assign bus.id_valid_o    = vld_p1;
  assign bus.id_instr_o    = instr_p1;
  assign bus.id_pc_o       = pc_p1;
  assign bus.id_pc_plus4_o = pc_plus4_p1;
  assign bus.halted_o      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a random phase
// scored against an instruction-stream model of the memory image.
module tb_instruction_fetch_stage;
  import fetch_pkg::*;

  localparam int          MEM_BYTES = 256;
  localparam logic [31:0] LAST      = 32'(MEM_BYTES - 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mem [64];
  int n_checks = 0;
  int n_fail = 0;

  fetch_if bus();

  instruction_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(MEM_BYTES)) return mem[a[7:2]];
    return 32'hDEAD_0000 ^ a;
  endfunction

  always_comb bus.imem_data_i = mem_word(bus.imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = t;
    @(negedge clk);
    bus.redirect_i    = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic        past_end, have_snap;
  logic [31:0] snap_pc, snap_instr;
  logic        ready_n, redir_n;
  logic [31:0] tgt;
  int          delivered;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.id_valid_o), 0);
    chk("rst_instr", bus.id_instr_o, 0);
    chk("rst_pc", bus.id_pc_o, 0);
    chk("rst_plus4", bus.id_pc_plus4_o, 0);
    chk("rst_halted", 32'(bus.halted_o), 0);
    chk("rst_addr", bus.imem_addr_o, 0);

    // 1: streaming from reset
    bus.id_ready_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_idle_valid", 32'(bus.id_valid_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(bus.id_valid_o), 1);
      chk("t1_instr", bus.id_instr_o, mem[i]);
      chk("t1_pc", bus.id_pc_o, 32'(4 * i));
      chk("t1_plus4", bus.id_pc_plus4_o, 32'(4 * i + 4));
    end

    // 2: stall holds everything
    bus.id_ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_valid", 32'(bus.id_valid_o), 1);
      chk("t2_pc", bus.id_pc_o, 32'd12);
      chk("t2_instr", bus.id_instr_o, mem[3]);
      chk("t2_addr", bus.imem_addr_o, 32'd16);
    end
    bus.id_ready_i = 1'b1;
    @(negedge clk);
    chk("t2_next_pc", bus.id_pc_o, 32'd16);
    chk("t2_next_instr", bus.id_instr_o, mem[4]);

    // 3: redirect while stalled
    bus.id_ready_i = 1'b0;
    redirect_to(32'h40);
    chk("t3_flush", 32'(bus.id_valid_o), 0);
    chk("t3_addr", bus.imem_addr_o, 32'h40);
    @(negedge clk);
    chk("t3_valid", 32'(bus.id_valid_o), 1);
    chk("t3_pc", bus.id_pc_o, 32'h40);
    chk("t3_instr", bus.id_instr_o, mem[16]);

    // 4: end of image, halt, resume
    bus.id_ready_i = 1'b1;
    redirect_to(32'hF0);
    chk("t4_flush", 32'(bus.id_valid_o), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_valid", 32'(bus.id_valid_o), 1);
      chk("t4_pc", bus.id_pc_o, 32'(32'hF0 + 4 * k));
      chk("t4_instr", bus.id_instr_o, mem[60 + k]);
    end
    repeat (2) begin
      @(negedge clk);
      chk("t4_halt_valid", 32'(bus.id_valid_o), 0);
      chk("t4_halted", 32'(bus.halted_o), 1);
      chk("t4_halt_addr", bus.imem_addr_o, 32'h100);
    end
    redirect_to(32'h10);
    chk("t4_unhalt", 32'(bus.halted_o), 0);
    chk("t4_resume_addr", bus.imem_addr_o, 32'h10);
    @(negedge clk);
    chk("t4_resume_pc", bus.id_pc_o, 32'h10);
    chk("t4_resume_instr", bus.id_instr_o, mem[4]);
    redirect_to(32'h200);
    chk("t4_far_halted", 32'(bus.halted_o), 1);
    chk("t4_far_valid", 32'(bus.id_valid_o), 0);
    redirect_to(32'h8);
    chk("t4_back_halted", 32'(bus.halted_o), 0);
    @(negedge clk);
    chk("t4_back_pc", bus.id_pc_o, 32'h8);

    // 5: asynchronous reset during a stall
    bus.id_ready_i = 1'b0;
    @(negedge clk);
    chk("t5_pre_valid", 32'(bus.id_valid_o), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.id_valid_o), 0);
    chk("t5_async_addr", bus.imem_addr_o, 0);
    chk("t5_async_pc", bus.id_pc_o, 0);
    chk("t5_async_halted", 32'(bus.halted_o), 0);
    @(negedge clk);
    bus.id_ready_i = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_valid", 32'(bus.id_valid_o), 0);
    @(negedge clk);
    chk("t5_first_pc", bus.id_pc_o, 0);
    chk("t5_first_instr", bus.id_instr_o, mem[0]);

    // 6: misaligned redirect
    redirect_to(32'h22);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_misalign", 32'(bus.misalign_o), 1);
    chk("t6_trap_valid", 32'(bus.id_valid_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_trap_hold", 32'(bus.misalign_o), 1);
      chk("t6_trap_novalid", 32'(bus.id_valid_o), 0);
    end
    redirect_to(32'h24);
    chk("t6_untrap", 32'(bus.misalign_o), 0);
    @(negedge clk);
    chk("t6_pc", bus.id_pc_o, 32'h24);
    chk("t6_instr", bus.id_instr_o, mem[9]);
`else
    chk("t6_addr", bus.imem_addr_o, 32'h20);
    @(negedge clk);
    chk("t6_pc", bus.id_pc_o, 32'h20);
    chk("t6_instr", bus.id_instr_o, mem[8]);
`endif

    // Random phase: expected stream is the memory image read in address order,
    // restarting at each redirect target and ending after the last word.
    bus.id_ready_i = 1'b0;
    redirect_to(32'h0);
    exp_pc    = 32'h0;
    past_end  = 1'b0;
    have_snap = 1'b0;
    delivered = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (past_end) begin
        chk("rnd_halted", 32'(bus.halted_o), 1);
        chk("rnd_halt_valid", 32'(bus.id_valid_o), 0);
      end
      if (have_snap) begin
        chk("rnd_stall_valid", 32'(bus.id_valid_o), 1);
        chk("rnd_stall_pc", bus.id_pc_o, snap_pc);
        chk("rnd_stall_instr", bus.id_instr_o, snap_instr);
      end
      ready_n = ($urandom_range(0, 3) != 0);
      redir_n = ($urandom_range(0, 15) == 0);
      tgt     = 32'($urandom_range(0, 72)) * 32'd4;
`ifndef FETCH_MISALIGN_TRAP_EN
      tgt     = tgt | 32'($urandom_range(0, 3));
`endif
      if (bus.id_valid_o) begin
        chk("rnd_pc", bus.id_pc_o, exp_pc);
        chk("rnd_instr", bus.id_instr_o, mem_word(exp_pc));
        chk("rnd_plus4", bus.id_pc_plus4_o, exp_pc + 32'd4);
        chk("rnd_inrange", 32'(exp_pc <= LAST), 1);
        if (ready_n) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      if (redir_n) exp_pc = tgt & ~32'h3;
      past_end   = (exp_pc > LAST);
      have_snap  = bus.id_valid_o && !ready_n && !redir_n;
      snap_pc    = bus.id_pc_o;
      snap_instr = bus.id_instr_o;
      bus.id_ready_i    = ready_n;
      bus.redirect_i    = redir_n;
      bus.redirect_pc_i = tgt;
    end
    @(negedge clk);
    chk("rnd_delivered", 32'(delivered > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
